// File: rtl/sega_joy_scan.sv
// sega_joy_scan: multi-port DB9 pad scanner (Atari / SMS / Mega Drive 3- and 6-button).
// Drives the shared select line through an 8-phase frame plus an idle tail, samples every
// port on the tick that ends each phase, and commits all ports atomically at the end of phase 7.
// Optional build macro: JOY_DEBOUNCE_EN (output bits only change after two agreeing frames).
module sega_joy_scan #(
    parameter int NUM_PORTS = 2,
    parameter int TICK_DIV  = 600,
    parameter int IDLE_PH   = 128
) (
    input  logic                      clk_sys,
    input  logic                      res_n_i,
    input  logic                      en_i,
    input  logic [6*NUM_PORTS-1:0]    pad_i,
    output logic                      sel_o,
    output logic [12*NUM_PORTS-1:0]   joy_o,
    output logic [NUM_PORTS-1:0]      six_btn_o,
    output logic                      frame_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDL_W = (IDLE_PH > 1) ? $clog2(IDLE_PH) : 1;
    localparam int JW    = 12 * NUM_PORTS;
    localparam int PW    = 6 * NUM_PORTS;

    typedef enum logic [3:0] {
        PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7, PH_IDLE
    } phase_t;

    phase_t           phase;
    logic [CNT_W-1:0] pre_cnt;
    logic [IDL_W-1:0] idle_cnt;
    logic             tick;

    logic [PW-1:0]        pad_p0;
    logic [PW-1:0]        pad_p1;
    logic [JW-1:0]        shadow;
    logic [NUM_PORTS-1:0] md;
    logic [NUM_PORTS-1:0] six;

    // Phase-ending tick; the whole sequencer stalls while en_i is low.
    assign tick = en_i && (pre_cnt == CNT_W'(TICK_DIV - 1));

    // Sequencer: prescaler, phase/idle counters, registered select line and commit strobe.
    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            phase    <= PH0;
            pre_cnt  <= '0;
            idle_cnt <= '0;
            sel_o    <= 1'b1;
            frame_o  <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (en_i) begin
                if (tick) begin
                    pre_cnt <= '0;
                    case (phase)
                        PH7: begin
                            frame_o <= 1'b1;
                            if (IDLE_PH == 0) begin
                                phase <= PH0;
                                sel_o <= 1'b0;
                            end else begin
                                phase    <= PH_IDLE;
                                idle_cnt <= '0;
                                sel_o    <= 1'b1;
                            end
                        end
                        PH_IDLE: begin
                            if (idle_cnt == IDL_W'(IDLE_PH - 1)) begin
                                phase <= PH0;
                                sel_o <= 1'b0;
                            end else begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end
                        default: begin
                            // Select alternates 0,1,0,1...: phase k+1 drives (k+1)[0].
                            phase <= phase_t'(phase + 4'd1);
                            sel_o <= ~phase[0];
                        end
                    endcase
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
        end
    end

`ifdef JOY_DEBOUNCE_EN
    logic [JW-1:0]        shadow_prev;
    logic [NUM_PORTS-1:0] six_prev;
    logic [JW-1:0]        joy_agree;
    logic [NUM_PORTS-1:0] six_agree;

    // A bit may only move when this frame and the previous one read the same value.
    assign joy_agree = ~(shadow ^ shadow_prev);
    assign six_agree = ~(six ^ six_prev);
`endif

    // Input synchroniser, per-phase sampling into the shadow word, and end-of-frame commit.
    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            pad_p0    <= '1;
            pad_p1    <= '1;
            shadow    <= '1;
            md        <= '0;
            six       <= '0;
            joy_o     <= '1;
            six_btn_o <= '0;
`ifdef JOY_DEBOUNCE_EN
            shadow_prev <= '1;
            six_prev    <= '0;
`endif
        end else begin
            pad_p0 <= pad_i;
            pad_p1 <= pad_p0;
            if (tick) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    case (phase)
                        PH1: begin
                            shadow[12*p +: 6] <= pad_p1[6*p +: 6];
                            md[p]             <= 1'b0;
                            six[p]            <= 1'b0;
                        end
                        PH2: begin
                            // Left+Right both low with select low is the Mega Drive signature.
                            if (!pad_p1[6*p+3] && !pad_p1[6*p+2]) begin
                                md[p]               <= 1'b1;
                                shadow[12*p+6 +: 2] <= pad_p1[6*p+4 +: 2];
                            end else begin
                                shadow[12*p+6 +: 2] <= 2'b11;
                            end
                        end
                        PH4: begin
                            if (md[p] && (pad_p1[6*p +: 4] == 4'h0)) begin
                                six[p] <= 1'b1;
                            end
                        end
                        PH5: begin
                            shadow[12*p+8 +: 4] <= six[p] ? pad_p1[6*p +: 4] : 4'hF;
                        end
                        default: ;
                    endcase
                end
                if (phase == PH7) begin
`ifdef JOY_DEBOUNCE_EN
                    joy_o       <= (joy_o & ~joy_agree) | (shadow & joy_agree);
                    six_btn_o   <= (six_btn_o & ~six_agree) | (six & six_agree);
                    shadow_prev <= shadow;
                    six_prev    <= six;
`else
                    joy_o     <= shadow;
                    six_btn_o <= six;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sega_joy_scan.sv
// Bench for sega_joy_scan: behavioural Atari / MD 3-button / MD 6-button pad models on the
// pad bus, a queue of expected frame words, and directed steps covering reset, pad types,
// frame timing, enable freeze and the single-frame glitch behaviour.
module tb_sega_joy_scan;

    localparam int NP    = 2;
    localparam int TD    = 4;
    localparam int IP    = 2;
    localparam int FRAME = (8 + IP) * TD;
`ifdef JOY_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          res_n_i;
    logic          en_i;
    logic [11:0]   pad_i;
    logic          sel_o;
    logic [23:0]   joy_o;
    logic [1:0]    six_btn_o;
    logic          frame_o;

    always #5 clk_sys = ~clk_sys;

    sega_joy_scan #(.NUM_PORTS(NP), .TICK_DIV(TD), .IDLE_PH(IP)) dut (
        .clk_sys   (clk_sys),
        .res_n_i   (res_n_i),
        .en_i      (en_i),
        .pad_i     (pad_i),
        .sel_o     (sel_o),
        .joy_o     (joy_o),
        .six_btn_o (six_btn_o),
        .frame_o   (frame_o)
    );

    // Pad types: 0 open, 1 Atari/SMS, 2 MD 3-button, 3 MD 6-button.
    // Buttons pressed = 1, in {M,X,Y,Z,S,A,C,B,R,L,D,U} order.
    int          ptype [NP];
    logic [11:0] btn   [NP];

    // 6-button pad internal counter: falling select edges, cleared after select sits high.
    logic sel_q  = 1'b1;
    int   fe_cnt = 0;
    int   hi_cnt = 0;
    int   fe_eff;

    always @(posedge clk_sys) begin
        sel_q <= sel_o;
        if (sel_q && !sel_o) fe_cnt <= fe_cnt + 1;
        if (sel_o) begin
            hi_cnt <= hi_cnt + 1;
            if (hi_cnt >= 6) fe_cnt <= 0;
        end else begin
            hi_cnt <= 0;
        end
    end

    function automatic logic [5:0] pad_pins(int t, logic [11:0] b, logic s, int fe);
        logic [11:0] n;
        n = ~b;
        case (t)
            1: pad_pins = {n[5], n[4], n[3:0]};
            2, 3: begin
                if (s) begin
                    if (t == 3 && fe == 3) pad_pins = {n[5], n[4], n[11:8]};
                    else                   pad_pins = {n[5], n[4], n[3:0]};
                end else begin
                    if (t == 3 && fe == 3)      pad_pins = {n[7], n[6], 4'h0};
                    else if (t == 3 && fe == 4) pad_pins = {n[7], n[6], 4'hF};
                    else                        pad_pins = {n[7], n[6], 2'b00, n[1:0]};
                end
            end
            default: pad_pins = 6'h3F;
        endcase
    endfunction

    // Pad bus: each port answers the current select level combinationally.
    always_comb begin
        fe_eff = fe_cnt + ((sel_q && !sel_o) ? 1 : 0);
        pad_i  = '1;
        for (int p = 0; p < NP; p++) begin
            pad_i[6*p +: 6] = pad_pins(ptype[p], btn[p], sel_o, fe_eff);
        end
    end

    function automatic logic [11:0] exp_word(int t, logic [11:0] b);
        case (t)
            1:       exp_word = {4'hF, 2'b11, ~b[5:4], ~b[3:0]};
            2:       exp_word = {4'hF, ~b[7:0]};
            3:       exp_word = ~b;
            default: exp_word = 12'hFFF;
        endcase
    endfunction

    typedef struct {
        logic [23:0] joy;
        logic [1:0]  six;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_raw(string tag, logic [23:0] j, logic [1:0] s);
        exp_t e;
        e.joy = j;
        e.six = s;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_model(string tag);
        push_raw(tag, {exp_word(ptype[1], btn[1]), exp_word(ptype[0], btn[0])},
                 {ptype[1] == 3, ptype[0] == 3});
    endtask

    // Wait for the next frame_o (bounded); on arrival compare against the queued expectation.
    task automatic wait_frame(output int cyc);
        exp_t e;
        cyc = 0;
        do begin
            @(negedge clk_sys);
            cyc++;
        end while (!frame_o && cyc < 1000);
        if (!frame_o) begin
            check("frame_timeout", {31'd0, frame_o}, 32'd1);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_joy"}, {8'd0, joy_o}, {8'd0, e.joy});
            check({e.tag, "_six"}, {30'd0, six_btn_o}, {30'd0, e.six});
        end
    endtask

    task automatic settle_and_check(string tag, output int cyc);
        int c;
        repeat (2) wait_frame(c);
        push_model(tag);
        wait_frame(cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int bad;
        logic [23:0] held;

        res_n_i = 1'b0;
        en_i    = 1'b1;
        for (int p = 0; p < NP; p++) begin
            ptype[p] = 0;
            btn[p]   = 12'h000;
        end

        // Reset values
        repeat (3) @(negedge clk_sys);
        check("rst_sel",   {31'd0, sel_o}, 32'd1);
        check("rst_joy",   {8'd0, joy_o}, 32'hFFFFFF);
        check("rst_six",   {30'd0, six_btn_o}, 32'd0);
        check("rst_frame", {31'd0, frame_o}, 32'd0);

        // First commit lands after the eight scan phases
        res_n_i = 1'b1;
        push_raw("open_ports", 24'hFFFFFF, 2'b00);
        wait_frame(c);
        check("first_frame_latency", c, 8 * TD);

        // Atari stick on port 0 (Up + button 1), port 1 open
        ptype[0] = 1; btn[0] = 12'h011;
        settle_and_check("atari", c);
        check("period_atari", c, FRAME);

        // MD 3-button on port 0: Start + A + C
        ptype[0] = 2; btn[0] = 12'h0E0;
        settle_and_check("md3", c);

        // MD 6-button on port 1: Mode + X + Right
        ptype[1] = 3; btn[1] = 12'hC08;
        settle_and_check("md6", c);
        check("period_md6", c, FRAME);
        @(negedge clk_sys);
        check("frame_pulse_width", {31'd0, frame_o}, 32'd0);

        // Enable held low for 50 cycles in phase 5
        held = {exp_word(ptype[1], btn[1]), exp_word(ptype[0], btn[0])};
        wait_frame(c);
        repeat (30) @(negedge clk_sys);
        check("en_sel_phase5", {31'd0, sel_o}, 32'd1);
        en_i = 1'b0;
        bad  = 0;
        repeat (50) begin
            @(negedge clk_sys);
            if (sel_o !== 1'b1 || joy_o !== held || frame_o !== 1'b0) bad++;
        end
        check("en_freeze_bad_cycles", bad, 0);
        en_i = 1'b1;
        wait_frame(c);
        check("en_frame_delay", 30 + 50 + c, FRAME + 50);

        // Single-frame Up glitch, then a sustained press, on an Atari stick
        ptype[0] = 1; btn[0] = 12'h000; ptype[1] = 0; btn[1] = 12'h000;
        settle_and_check("glitch_base", c);
        btn[0] = 12'h001;
        push_raw("glitch_one", DEB ? 24'hFFFFFF : 24'hFFFFFE, 2'b00);
        wait_frame(c);
        btn[0] = 12'h000;
        push_raw("glitch_gone", 24'hFFFFFF, 2'b00);
        wait_frame(c);
        btn[0] = 12'h001;
        push_raw("press_first", DEB ? 24'hFFFFFF : 24'hFFFFFE, 2'b00);
        wait_frame(c);
        push_raw("press_second", 24'hFFFFFE, 2'b00);
        wait_frame(c);

        // Reset in the middle of phase 3 with a 6-button pad present
        ptype[1] = 3; btn[1] = 12'h000;
        settle_and_check("pre_reset", c);
        repeat (21) @(negedge clk_sys);
        res_n_i = 1'b0;
        #1;
        check("midrst_sel",   {31'd0, sel_o}, 32'd1);
        check("midrst_joy",   {8'd0, joy_o}, 32'hFFFFFF);
        check("midrst_six",   {30'd0, six_btn_o}, 32'd0);
        check("midrst_frame", {31'd0, frame_o}, 32'd0);
        @(negedge clk_sys);
        res_n_i = 1'b1;
        wait_frame(c);
        check("midrst_first_frame_latency", c, 8 * TD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
